tile_map_writer: RTL and testbench

- Upstream stage of the VGA tile renderer; owns the tile map the renderer reads.
- Accepts Avalon tile-update writes (x, y, sprite type) from the HPS.
- Queues the updates in a command FIFO and commits them to a dual-port map RAM only during frame blanking, so a frame never shows a half-applied update.
- Provides a registered read port that the renderer indexes with its current tile column and row.

---
 rtl/tile_map_writer.sv | 205 ++++++++++++++++++++
 tb/tb_tile_map_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_writer.sv
// Tile map owner for the VGA tile renderer: buffers HPS tile updates in a
// command FIFO and commits them to the map RAM only while the display blanks.
module tile_map_writer #(
   parameter int COLS       = 40,
   parameter int ROWS       = 30,
   parameter int TYPE_W     = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [2:0]        address,
   input  logic [7:0]        writedata,
   output logic [7:0]        readdata,
   input  logic              frame_blank,
   input  logic [5:0]        rd_col,
   input  logic [4:0]        rd_row,
   output logic [TYPE_W-1:0] rd_type
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic              cmd;
      logic [7:0]        x;
      logic [7:0]        y;
      logic [TYPE_W-1:0] typ;
   } entry_t;

   typedef enum logic [1:0] {IDLE, APPLY, CLEAR} state_t;

   logic [7:0]        x_stage;
   logic [7:0]        y_stage;
   logic              overflow;
   entry_t            fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   state_t            state;
   state_t            next_state;
   entry_t            cur;
   logic [AW-1:0]     clr_idx;
   logic [TYPE_W-1:0] map_mem [CELLS];

   logic              wr_sel;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              empty;
   logic              full;
   logic              busy;
   entry_t            push_entry;
   logic              map_we;
   logic [AW-1:0]     map_addr;
   logic [TYPE_W-1:0] map_data;
   logic              rd_in_range;
   logic [AW-1:0]     rd_idx;

   assign wr_sel   = chipselect && write;
   assign push_req = wr_sel && ((address == 3'd2) || (address == 3'd3 && writedata[0]));
   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req && (!full || pop);
   assign busy     = (state != IDLE) || !empty;

   // Build the FIFO entry: a tile update from the staged coordinates, or a clear command
   always_comb begin
      push_entry = '0;
      if (address == 3'd2) begin
         push_entry.cmd = 1'b0;
         push_entry.x   = x_stage;
         push_entry.y   = y_stage;
         push_entry.typ = TYPE_W'(writedata);
      end else begin
         push_entry.cmd = 1'b1;
      end
   end

   // Staging registers for the coordinates of the next update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_stage <= '0;
         y_stage <= '0;
      end else if (wr_sel) begin
         if (address == 3'd0) x_stage <= writedata;
         if (address == 3'd1) y_stage <= writedata;
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= push_entry;
   end

   // FIFO pointers, occupancy and the sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop);
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (wr_sel && address == 3'd3 && writedata[1])
            overflow <= 1'b0;
      end
   end

   // Commit FSM: decide pops, map writes and the next state
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      map_we     = 1'b0;
      map_addr   = '0;
      map_data   = '0;
      case (state)
         IDLE: begin
            if (frame_blank && !empty) begin
               pop        = 1'b1;
               next_state = APPLY;
            end
         end
         APPLY: begin
            if (cur.cmd) begin
               next_state = CLEAR;
            end else begin
               if (int'(cur.x) < COLS && int'(cur.y) < ROWS) begin
                  map_we   = 1'b1;
                  map_addr = AW'(int'(cur.y) * COLS + int'(cur.x));
                  map_data = cur.typ;
               end
               if (frame_blank && !empty)
                  pop = 1'b1;
               else
                  next_state = IDLE;
            end
         end
         CLEAR: begin
            if (frame_blank) begin
               map_we = 1'b1;
               map_addr = clr_idx;
               if (clr_idx == AW'(CELLS - 1)) next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // FSM state, the entry being applied and the clear sweep index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         cur     <= '0;
         clr_idx <= '0;
      end else begin
         state <= next_state;
         if (pop) cur <= fifo_mem[rd_ptr];
         if (state == APPLY && cur.cmd)
            clr_idx <= '0;
         else if (state == CLEAR && frame_blank)
            clr_idx <= clr_idx + 1'b1;
      end
   end

   // Map RAM write port
   always_ff @(posedge clk) begin
      if (map_we) map_mem[map_addr] <= map_data;
   end

   assign rd_in_range = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
   assign rd_idx      = AW'(int'(rd_row) * COLS + int'(rd_col));

   // Renderer read port; a same-cycle write to the cell is seen one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_type <= '0;
      else
         rd_type <= rd_in_range ? map_mem[rd_idx] : '0;
   end

   // Avalon read data, one cycle after the strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (chipselect && read) begin
         case (address)
            3'd0:    readdata <= x_stage;
            3'd1:    readdata <= y_stage;
            3'd3:    readdata <= {overflow, busy, 1'b0, 5'(count)};
            default: readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_map_writer.sv
// Self-checking bench for tile_map_writer: directed scenarios plus random
// update batches compared against a map/queue model of the commit rules.
module tb_tile_map_writer;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       chipselect;
   logic       write;
   logic       read;
   logic [2:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       frame_blank;
   logic [5:0] rd_col;
   logic [4:0] rd_row;
   logic [7:0] rd_type;

   typedef struct {
      bit clr;
      int x;
      int y;
      int t;
   } ent_t;

   ent_t q[$];
   bit   model_ov;
   int   model_map [ROWS][COLS];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] rv;

   tile_map_writer #(.COLS(COLS), .ROWS(ROWS), .TYPE_W(8), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .frame_blank(frame_blank), .rd_col(rd_col), .rd_row(rd_row), .rd_type(rd_type)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic av_write(input logic [2:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      step();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic av_read(input logic [2:0] a, output logic [7:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      step();
      d = readdata;
      chipselect = 1'b0; read = 1'b0;
   endtask

   // Push one FIFO entry through the register interface and into the model queue
   task automatic applyStimulus(input bit clr, input int x, input int y, input int t);
      ent_t e;
      e.clr = clr; e.x = x; e.y = y; e.t = t;
      if (clr) begin
         av_write(3'd3, 8'h01);
      end else begin
         av_write(3'd0, 8'(x));
         av_write(3'd1, 8'(y));
         av_write(3'd2, 8'(t));
      end
      if (q.size() < DEPTH) q.push_back(e);
      else model_ov = 1'b1;
   endtask

   task automatic drain_model();
      ent_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.clr) begin
            foreach (model_map[r, c]) model_map[r][c] = 0;
         end else if (e.x < COLS && e.y < ROWS) begin
            model_map[e.y][e.x] = e.t;
         end
      end
   endtask

   task automatic read_cell(input string tag, input int c, input int r, input int exp);
      rd_col = 6'(c); rd_row = 5'(r);
      step();
      checkOutput(tag, rd_type, exp);
   endtask

   task automatic scan_map(input string tag);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            read_cell(tag, c, r, model_map[r][c]);
   endtask

   function automatic logic [7:0] status_exp();
      return {model_ov, q.size() != 0, 1'b0, 5'(q.size())};
   endfunction

   // Directed scenarios followed by randomized batches
   initial begin
      int n;
      reset = 1'b1; frame_blank = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = '0; writedata = '0; rd_col = '0; rd_row = '0;
      model_ov = 1'b0;
      foreach (model_map[r, c]) model_map[r][c] = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_readdata", readdata, 0);
      checkOutput("reset_rd_type", rd_type, 0);
      reset = 1'b0;

      // automatic clear after reset
      repeat (1300) step();
      av_read(3'd3, rv);
      checkOutput("post_reset_status", rv, 8'h00);
      scan_map("init_map");

      // single update held back until blanking
      frame_blank = 1'b0;
      applyStimulus(1'b0, 5, 7, 2);
      av_read(3'd3, rv);
      checkOutput("single_status", rv, 8'h41);
      av_read(3'd0, rv);
      checkOutput("x_stage_read", rv, 8'd5);
      av_read(3'd1, rv);
      checkOutput("y_stage_read", rv, 8'd7);
      av_read(3'd5, rv);
      checkOutput("unmapped_read", rv, 8'h00);
      read_cell("single_not_blank", 5, 7, 0);
      frame_blank = 1'b1;
      repeat (3) step();
      checkOutput("single_committed", rd_type, 8'd2);
      drain_model();
      av_read(3'd3, rv);
      checkOutput("single_drained", rv, 8'h00);

      // overflow with 17 pushes
      frame_blank = 1'b0;
      for (int i = 0; i < 17; i++)
         applyStimulus(1'b0, 3 + i, 10 + (i % 5), 8'h60 + i);
      av_read(3'd3, rv);
      checkOutput("overflow_status", rv, 8'hD0);
      av_write(3'd3, 8'h02);
      model_ov = 1'b0;
      av_read(3'd3, rv);
      checkOutput("overflow_cleared", rv, 8'h50);
      frame_blank = 1'b1;
      repeat (40) step();
      drain_model();
      scan_map("overflow_map");

      // ordering: update, clear, update
      frame_blank = 1'b0;
      applyStimulus(1'b0, 1, 1, 1);
      applyStimulus(1'b1, 0, 0, 0);
      applyStimulus(1'b0, 2, 2, 3);
      frame_blank = 1'b1;
      repeat (1250) step();
      drain_model();
      read_cell("order_first_erased", 1, 1, 0);
      read_cell("order_second_kept", 2, 2, 3);
      scan_map("order_map");

      // out-of-range update is discarded silently
      frame_blank = 1'b0;
      applyStimulus(1'b0, 45, 3, 9);
      frame_blank = 1'b1;
      repeat (10) step();
      drain_model();
      av_read(3'd3, rv);
      checkOutput("oob_status", rv, 8'h00);
      scan_map("oob_map");

      // markers around the clear pause point, plus an alias target for range checks
      frame_blank = 1'b0;
      applyStimulus(1'b0, 0, 0, 8'h11);
      applyStimulus(1'b0, 20, 12, 8'h22);
      applyStimulus(1'b0, 0, 3, 8'h33);
      applyStimulus(1'b0, 20, 17, 8'h44);
      applyStimulus(1'b0, 39, 29, 8'h55);
      frame_blank = 1'b1;
      repeat (20) step();
      drain_model();
      read_cell("marker_0_3", 0, 3, 8'h33);
      read_cell("rd_col_out_of_range", 40, 2, 0);
      read_cell("rd_both_out_of_range", 63, 31, 0);
      read_cell("marker_39_29", 39, 29, 8'h55);

      // clear paused at index 600 then resumed
      frame_blank = 1'b0;
      applyStimulus(1'b1, 0, 0, 0);
      frame_blank = 1'b1;
      repeat (602) step();
      frame_blank = 1'b0;
      repeat (100) step();
      av_read(3'd3, rv);
      checkOutput("pause_busy", rv, 8'h40);
      read_cell("pause_low_cleared", 0, 0, 0);
      read_cell("pause_500_cleared", 20, 12, 0);
      read_cell("pause_700_kept", 20, 17, 8'h44);
      read_cell("pause_1199_kept", 39, 29, 8'h55);
      frame_blank = 1'b1;
      repeat (590) step();
      frame_blank = 1'b0;
      read_cell("resume_1199_not_yet", 39, 29, 8'h55);
      frame_blank = 1'b1;
      repeat (20) step();
      drain_model();
      av_read(3'd3, rv);
      checkOutput("resume_done", rv, 8'h00);
      scan_map("resume_map");

      // random batches
      for (int round = 0; round < 4; round++) begin
         frame_blank = 1'b0;
         n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(7, 0) == 0)
               applyStimulus(1'b1, 0, 0, 0);
            else
               applyStimulus(1'b0, $urandom_range(47, 0), $urandom_range(33, 0), $urandom_range(255, 0));
         end
         av_read(3'd3, rv);
         checkOutput("rand_status", rv, status_exp());
         if (model_ov) begin
            av_write(3'd3, 8'h02);
            model_ov = 1'b0;
         end
         frame_blank = 1'b1;
         repeat (1300) step();
         drain_model();
         av_read(3'd3, rv);
         checkOutput("rand_drained", rv, 8'h00);
         scan_map("rand_map");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
